// File: rtl/tqvp_intercal_alu_seq_if.sv
// TinyQV peripheral bus bundle for the INTERCAL ALU.
//   address      : register address (6 bits)
//   data_in      : write data
//   data_write_n : 11 none, 00 byte, 01 half, 10 word
//   data_read_n  : 11 none, 00 byte, 01 half, 10 word
//   data_out     : read data (combinational)
//   data_ready   : access completion
// master = bus driver (CPU / testbench), slave = peripheral.
interface tqvp_intercal_alu_seq_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    modport master (
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready
    );

    modport slave (
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready
    );
endinterface

// File: rtl/tqvp_intercal_alu_seq.sv
// Bit-serial INTERCAL ALU peripheral (MINGLE, SELECT, unary AND/OR/XOR).
// Operands A and B are latched through the bus; a CMD write starts a run
// that produces one result bit per clock for WIDTH clocks.
// Ports:
//   clk      : clock
//   rst_n    : synchronous active-low reset
//   i_ui_in  : unused
//   o_uo_out : {busy, done, error, 5'b0}
//   bus      : TinyQV peripheral bus (slave modport)
// Parameters:
//   WIDTH       : 16 or 32 operand/result width
//   STALL_READS : 1 = RESULT reads wait for completion while busy
module tqvp_intercal_alu_seq #(
    parameter int WIDTH       = 32,
    parameter bit STALL_READS = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    i_ui_in,
    output logic [7:0]                    o_uo_out,
    tqvp_intercal_alu_seq_if.slave        bus
);
    localparam int JW = $clog2(WIDTH);

    localparam logic [2:0] OP_MINGLE = 3'd0;
    localparam logic [2:0] OP_SELECT = 3'd1;
    localparam logic [2:0] OP_UAND   = 3'd2;
    localparam logic [2:0] OP_UOR    = 3'd3;
    localparam logic [2:0] OP_UXOR   = 3'd4;

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t r_state, w_state_next;

    logic [WIDTH-1:0] r_a, r_b, r_result;
    logic [JW-1:0]    r_j, r_k;
    logic [2:0]       r_op;
    logic             r_chain, r_done, r_error, r_overrun;

    logic             w_busy, w_wr, w_rd, w_hit_ctl, w_cmd_wr, w_op_valid, w_last;
    logic             w_bit;
    logic [WIDTH-1:0] w_a_rot, w_result_upd;
    logic [JW-1:0]    w_k_next, w_half;
    logic [31:0]      w_rd_raw, w_data_out;
    logic             w_unused_ui;

    assign w_unused_ui = ^i_ui_in;

    assign w_wr       = (bus.data_write_n != 2'b11);
    assign w_rd       = (bus.data_read_n  != 2'b11);
    // Addresses whose writes are refused (and flagged) during a run.
    assign w_hit_ctl  = (bus.address == 6'h00) || (bus.address == 6'h02) ||
                        (bus.address == 6'h04) || (bus.address == 6'h06) ||
                        (bus.address == 6'h08);
    assign w_cmd_wr   = w_wr && (bus.address == 6'h08);
    assign w_op_valid = (bus.data_in[2:0] <= OP_UXOR);
    assign w_last     = (r_j == JW'(WIDTH - 1));

    // Merge a bus write into an operand register according to access width.
    function automatic logic [WIDTH-1:0] f_merge(
        input logic [WIDTH-1:0] cur,
        input logic             hit_lo,
        input logic             hit_hi,
        input logic [1:0]       wn,
        input logic [31:0]      din
    );
        logic [31:0] v;
        v = 32'(cur);
        if (hit_lo) begin
            case (wn)
                2'b00:   v[7:0]  = din[7:0];
                2'b01:   v[15:0] = din[15:0];
                2'b10:   v       = din;
                default: ;
            endcase
        end
        // High half exists only in the 32-bit build and only for 16-bit writes.
        if (hit_hi && (wn == 2'b01) && (WIDTH == 32)) v[31:16] = din[15:0];
        return v[WIDTH-1:0];
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd_wr && w_op_valid) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_busy   = (r_state == S_RUN);
        o_uo_out = {w_busy, r_done, r_error, 5'b0};
    end

    // ---------------- Bit-serial datapath ----------------
    // w_a_rot[j] = A[(j+1) mod W], the neighbour used by the unary ops.
    assign w_a_rot = {r_a[0], r_a[WIDTH-1:1]};
    assign w_half  = {1'b0, r_j[JW-1:1]};

    always_comb begin
        w_bit = 1'b0;
        case (r_op)
            OP_MINGLE: w_bit = r_j[0] ? r_a[w_half] : r_b[w_half];
            OP_SELECT: w_bit = r_a[r_j];
            OP_UAND:   w_bit = r_a[r_j] & w_a_rot[r_j];
            OP_UOR:    w_bit = r_a[r_j] | w_a_rot[r_j];
            OP_UXOR:   w_bit = r_a[r_j] ^ w_a_rot[r_j];
            default:   w_bit = 1'b0;
        endcase
    end

    // SELECT packs selected bits from the bottom using its own write index k.
    always_comb begin
        w_result_upd = r_result;
        w_k_next     = r_k;
        if (r_op == OP_SELECT) begin
            if (r_b[r_j]) begin
                w_result_upd[r_k] = w_bit;
                w_k_next          = r_k + 1'b1;
            end
        end else begin
            w_result_upd[r_j] = w_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_op      <= '0;
            r_chain   <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_busy) begin
                r_result <= w_result_upd;
                r_k      <= w_k_next;
                r_j      <= r_j + 1'b1;
                if (w_last) begin
                    r_done <= 1'b1;
                    if (r_chain) r_a <= w_result_upd;
                end
            end else if (w_wr) begin
                r_a <= f_merge(r_a, bus.address == 6'h00, bus.address == 6'h02,
                               bus.data_write_n, bus.data_in);
                r_b <= f_merge(r_b, bus.address == 6'h04, bus.address == 6'h06,
                               bus.data_write_n, bus.data_in);
                if (w_cmd_wr) begin
                    r_result <= '0;
                    if (w_op_valid) begin
                        r_j     <= '0;
                        r_k     <= '0;
                        r_op    <= bus.data_in[2:0];
                        r_chain <= bus.data_in[3];
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                    end else begin
                        // Reserved op completes immediately with an error.
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                    end
                end
            end

            if (w_wr && w_busy && w_hit_ctl)
                r_overrun <= 1'b1;
            else if (w_wr && (bus.address == 6'h10) && bus.data_in[3])
                r_overrun <= 1'b0;
        end
    end

    // ---------------- Read path ----------------
    always_comb begin
        w_rd_raw = '0;
        case (bus.address)
            6'h00:   w_rd_raw = 32'(r_a);
            6'h02:   w_rd_raw = 32'(r_a) >> 16;
            6'h04:   w_rd_raw = 32'(r_b);
            6'h06:   w_rd_raw = 32'(r_b) >> 16;
            6'h0C:   w_rd_raw = 32'(r_result);
            6'h0E:   w_rd_raw = 32'(r_result) >> 16;
            6'h10:   w_rd_raw = {28'd0, r_overrun, r_error, r_done, w_busy};
            default: w_rd_raw = '0;
        endcase
    end

    always_comb begin
        w_data_out = '0;
        case (bus.data_read_n)
            2'b00:   w_data_out = {24'd0, w_rd_raw[7:0]};
            2'b01:   w_data_out = {16'd0, w_rd_raw[15:0]};
            2'b10:   w_data_out = w_rd_raw;
            default: w_data_out = '0;
        endcase
    end

    assign bus.data_out   = w_data_out;
    assign bus.data_ready = !(STALL_READS && w_busy && w_rd &&
                              ((bus.address == 6'h0C) || (bus.address == 6'h0E)));
endmodule
